// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Majority-vote sampling is selected with UART_RX_MAJORITY_VOTE_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Mid-bit sampler. With UART_RX_MAJORITY_VOTE_EN it takes a 2-of-3 vote around
// the sample point; otherwise a single sample. Result is valid from edge M+2.
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
(
    input  logic       UCLK,
    input  logic       reset,
    input  logic       RX_IN,
    input  logic [4:0] edge_count,
    input  logic [5:0] prescale,
    output logic       sampled_bit
);

    logic [4:0] w_mid;
    logic       r_s1;
    logic       r_bit;

    assign w_mid       = 5'(prescale >> 1);
    assign sampled_bit = r_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_s0;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_s0  <= 1'b1;
            r_s1  <= 1'b1;
            r_bit <= 1'b1;
        end else begin
            if (edge_count == w_mid - 5'd1) r_s0 <= RX_IN;
            if (edge_count == w_mid)        r_s1 <= RX_IN;
            // third sample is taken live at M+1 and folded straight into the vote
            if (edge_count == w_mid + 5'd1)
                r_bit <= (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
        end
    end
`else
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b1;
            r_bit <= 1'b1;
        end else begin
            if (edge_count == w_mid)        r_s1  <= RX_IN;
            // extra stage keeps result timing identical to the voting build
            if (edge_count == w_mid + 5'd1) r_bit <= r_s1;
        end
    end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer, parity and stop checks.
// Bit sampling style depends on UART_RX_MAJORITY_VOTE_EN (see sampler).
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            edge_count,
    input  logic                  edge_count_done,
    output logic                  edge_cnt_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic                  r_dv;
    logic                  r_pe;
    logic                  r_se;
    logic                  w_bit;

    uart_rx_bit_sampler u_sampler (
        .UCLK        (UCLK),
        .reset       (reset),
        .RX_IN       (RX_IN),
        .edge_count  (edge_count),
        .prescale    (prescale),
        .sampled_bit (w_bit)
    );

    assign edge_cnt_en  = (r_state != IDLE);
    assign busy         = (r_state != IDLE);
    assign P_DATA       = r_pdata;
    assign data_valid   = r_dv;
    assign parity_error = r_pe;
    assign stop_error   = r_se;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_pdata   <= '0;
            r_idx     <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_par_bad <= 1'b0;
            r_dv      <= 1'b0;
            r_pe      <= 1'b0;
            r_se      <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!RX_IN && prescale_legal(prescale)) begin
                        r_state   <= START;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_par_bad <= 1'b0;
                        r_shreg   <= '0;
                        r_idx     <= '0;
                    end
                end
                START: begin
                    if (edge_count_done) begin
                        // a high start sample means the falling edge was a glitch
                        r_state <= w_bit ? IDLE : DATA;
                        r_idx   <= '0;
                    end
                end
                DATA: begin
                    if (edge_count_done) begin
                        r_shreg[r_idx] <= w_bit;
                        if (r_idx == IDX_W'(DATA_WIDTH - 1))
                            r_state <= r_par_en ? PARITY : STOP;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (edge_count_done) begin
                        if (w_bit != ((^r_shreg) ^ r_par_typ))
                            r_par_bad <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (edge_count_done) begin
                        r_state <= IDLE;
                        r_se    <= ~w_bit;
                        r_pe    <= r_par_bad;
                        if (w_bit && !r_par_bad) begin
                            r_dv    <= 1'b1;
                            r_pdata <= r_shreg;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames, bench-side edge counter,
// expected status/byte pushed per frame and popped by a pulse monitor.
module tb_uart_rx_ctrl;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } exp_t;

    logic       UCLK;
    logic       reset;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] edge_count;
    logic       edge_count_done;
    logic       edge_cnt_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .UCLK            (UCLK),
        .reset           (reset),
        .RX_IN           (RX_IN),
        .prescale        (prescale),
        .PAR_EN          (PAR_EN),
        .PAR_TYP         (PAR_TYP),
        .edge_count      (edge_count),
        .edge_count_done (edge_count_done),
        .edge_cnt_en     (edge_cnt_en),
        .P_DATA          (P_DATA),
        .data_valid      (data_valid),
        .parity_error    (parity_error),
        .stop_error      (stop_error),
        .busy            (busy)
    );

    initial UCLK = 1'b0;
    always #5 UCLK = ~UCLK;

    // edge counter model: counts while enabled, wraps after the last edge
    assign edge_count_done = edge_cnt_en && ({1'b0, edge_count} == prescale - 6'd1);
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset)                             edge_count <= '0;
        else if (!edge_cnt_en || edge_count_done) edge_count <= '0;
        else                                   edge_count <= edge_count + 5'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge UCLK) begin
        if (!reset && (data_valid || parity_error || stop_error)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("status_dv_pe_se", {29'd0, data_valid, parity_error, stop_error},
                    {29'd0, e.dv, e.pe, e.se});
                chk("p_data", {24'd0, P_DATA}, {24'd0, e.data});
            end
        end
    end

    task automatic push(input logic dv, input logic pe, input logic se, input logic [7:0] d);
        exp_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.data = d;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge UCLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // hold a line level for n cycles; optional one-cycle flip when edge_count == M
    task automatic drive_bit(input logic b, input int n, input logic glitch);
        logic [4:0] m;
        m = 5'(prescale >> 1);
        for (int i = 0; i < n; i++) begin
            RX_IN = (glitch && edge_count == m) ? ~b : b;
            tick();
        end
        RX_IN = b;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [5:0] p, input logic pen,
                              input logic pbit, input logic sbit, input int gbit);
        prescale = p;
        PAR_EN   = pen;
        drive_bit(1'b0, int'(p), 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], int'(p), (gbit == i));
        if (pen) drive_bit(pbit, int'(p), 1'b0);
        drive_bit(sbit, int'(p), 1'b0);
    endtask

    initial begin
        logic [7:0] rst_byte;
        reset    = 1'b1;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        tick(); tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_en", {31'd0, edge_cnt_en}, 32'd0);
        chk("reset_pdata", {24'd0, P_DATA}, 32'd0);
        chk("reset_pulses", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
        reset = 1'b0;
        idle(4);

        // 0xA5, prescale 8, no parity
        push(1'b1, 1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);

        // 0x3C, prescale 16, even parity; parity bit 0 is correct (four ones)
        PAR_TYP = 1'b0;
        push(1'b1, 1'b0, 1'b0, 8'h3C);
        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, -1);
        idle(4);
        push(1'b0, 1'b1, 1'b0, 8'h3C);
        send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, -1);
        idle(4);

        // false start at prescale 32
        prescale = 6'd32;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 6, 1'b0);
        RX_IN = 1'b1;
        chk("abort_en_active", {31'd0, edge_cnt_en}, 32'd1);
        chk("abort_busy_active", {31'd0, busy}, 32'd1);
        idle(40);
        chk("abort_en_dropped", {31'd0, edge_cnt_en}, 32'd0);
        chk("abort_busy_dropped", {31'd0, busy}, 32'd0);

        // 0x81 with bad stop bit, then 0x55 back-to-back
        push(1'b0, 1'b0, 1'b1, 8'h3C);
        send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, -1);
        push(1'b1, 1'b0, 1'b0, 8'h55);
        send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);

        // glitch on data bit 3 of 0x5A at the sample point
`ifdef UART_RX_MAJORITY_VOTE_EN
        push(1'b1, 1'b0, 1'b0, 8'h5A);
`else
        push(1'b1, 1'b0, 1'b0, 8'h52);
`endif
        send_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b1, 3);
        idle(4);

        // reset during data bit 4
        rst_byte = 8'hF0;
        prescale = 6'd8;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rst_byte[i], 8, 1'b0);
        drive_bit(rst_byte[4], 4, 1'b0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_en", {31'd0, edge_cnt_en}, 32'd0);
        chk("midreset_pdata", {24'd0, P_DATA}, 32'd0);
        chk("midreset_pulses", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
        tick();
        reset = 1'b0;
        idle(4);
        push(1'b1, 1'b0, 1'b0, 8'h0F);
        send_frame(8'h0F, 6'd8, 1'b0, 1'b0, 1'b1, -1);
        idle(20);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
